// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the round-robin Wishbone crossbar:
// index widths, address-region hit test and round-robin pick.
package wb_xbar_pkg;

  localparam int unsigned MAX_NM   = 8;
  localparam int unsigned MAX_NM_W = 3;
  localparam int unsigned HIT_W    = 64;

  typedef struct packed {
    logic                found;
    logic [MAX_NM_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  function automatic logic region_hit(input logic [HIT_W-1:0] adr,
                                      input logic [HIT_W-1:0] base,
                                      input logic [HIT_W-1:0] mask);
    return (adr & mask) == base;
  endfunction

  // First requester at or after ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_NM-1:0]   req,
                                       input logic [MAX_NM_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_NM; i++) begin
      j = (32'(ptr) + i) % n;
      if (i < n && !r.found && req[j[MAX_NM_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[MAX_NM_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_crossbar_rr_arbiter.sv
// Per-slave round-robin arbiter: IDLE/BUSY FSM holding a one-hot grant
// until the granted master drops CYC.
module wb_rr_arbiter
  import wb_xbar_pkg::*;
#(
  parameter int unsigned NM = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] cyc,
  output logic [NM-1:0] grant
);

  localparam int unsigned IW = idx_w(NM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [IW-1:0] gnt_idx, gnt_idx_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [NM-1:0] grant_n;
  rr_pick_t      pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
      grant   <= '0;
    end else begin
      state   <= state_n;
      gnt_idx <= gnt_idx_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_idx_n = gnt_idx;
    ptr_n     = ptr;
    grant_n   = grant;
    pick      = rr_pick(MAX_NM'(req), MAX_NM_W'(ptr), NM);
    case (state)
      IDLE: begin
        if (pick.found) begin
          state_n            = BUSY;
          gnt_idx_n          = IW'(pick.idx);
          grant_n            = '0;
          grant_n[gnt_idx_n] = 1'b1;
        end
      end
      BUSY: begin
        // Release on CYC drop; next search starts just past the old owner.
        if (!cyc[gnt_idx]) begin
          state_n = IDLE;
          grant_n = '0;
          ptr_n   = (gnt_idx == IW'(NM - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/wb_crossbar_rr.sv
// NM x NS Wishbone classic crossbar: address decode, per-slave round-robin
// arbitration with CYC-long lock, and ERR responder for unmapped accesses.
module wb_crossbar_rr
  import wb_xbar_pkg::*;
#(
  parameter int unsigned          NM         = 2,
  parameter int unsigned          NS         = 6,
  parameter int unsigned          AW         = 32,
  parameter int unsigned          DW         = 32,
  parameter logic [NS*AW-1:0]     SLAVE_BASE = {NS{32'h0}},
  parameter logic [NS*AW-1:0]     SLAVE_MASK = {NS{32'hFFF00000}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NM-1:0]          m_cyc,
  input  logic [NM-1:0]          m_stb,
  input  logic [NM-1:0]          m_we,
  input  logic [NM*AW-1:0]       m_adr,
  input  logic [NM*DW-1:0]       m_dat_o,
  input  logic [NM*(DW/8)-1:0]   m_sel,
  output logic [NM*DW-1:0]       m_dat_i,
  output logic [NM-1:0]          m_ack,
  output logic [NM-1:0]          m_err,
  output logic [NS-1:0]          s_cyc,
  output logic [NS-1:0]          s_stb,
  output logic [NS-1:0]          s_we,
  output logic [NS*AW-1:0]       s_adr,
  output logic [NS*DW-1:0]       s_dat_o,
  output logic [NS*(DW/8)-1:0]   s_sel,
  input  logic [NS*DW-1:0]       s_dat_i,
  input  logic [NS-1:0]          s_ack,
  input  logic [NS-1:0]          s_err
);

  localparam int unsigned SELW = DW / 8;
  localparam int unsigned SW   = idx_w(NS);

  logic [NM-1:0] mapped;
  logic [NM-1:0] locked;
  logic [NM-1:0] unmapped_req;
  logic [NM-1:0] err_pending;
  logic [SW-1:0] dsel  [NM];
  logic [NM-1:0] req_s [NS];
  logic [NM-1:0] gnt   [NS];

  // Address decode, lowest-numbered slave wins on overlap.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      mapped[m] = 1'b0;
      dsel[m]   = '0;
      for (int s = 0; s < NS; s++) begin
        if (!mapped[m] && region_hit(HIT_W'(m_adr[m*AW +: AW]),
                                     HIT_W'(SLAVE_BASE[s*AW +: AW]),
                                     HIT_W'(SLAVE_MASK[s*AW +: AW]))) begin
          mapped[m] = 1'b1;
          dsel[m]   = SW'(s);
        end
      end
    end
  end

  // A master already holding a grant is invisible to every arbiter.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      locked[m] = 1'b0;
      for (int s = 0; s < NS; s++) locked[m] = locked[m] | gnt[s][m];
    end
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        req_s[s][m] = m_cyc[m] & m_stb[m] & mapped[m] & ~locked[m] & (dsel[m] == SW'(s));
      end
    end
  end

  assign unmapped_req = m_cyc & m_stb & ~mapped & ~locked;

  always_ff @(posedge clk) begin
    if (rst) err_pending <= '0;
    else     err_pending <= unmapped_req;
  end

  for (genvar s = 0; s < NS; s++) begin : g_arb
    wb_rr_arbiter #(.NM(NM)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_s[s]),
      .cyc   (m_cyc),
      .grant (gnt[s])
    );
  end

  // Routing: slave bus follows its owner, owner sees its slave's response.
  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = '0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    m_ack   = '0;
    m_err   = err_pending & m_cyc;
    m_dat_i = '0;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < NM; m++) begin
        if (gnt[s][m]) begin
          s_cyc[s]                = m_cyc[m];
          s_stb[s]                = m_stb[m];
          s_we[s]                 = m_we[m];
          s_adr[s*AW +: AW]       = m_adr[m*AW +: AW];
          s_dat_o[s*DW +: DW]     = m_dat_o[m*DW +: DW];
          s_sel[s*SELW +: SELW]   = m_sel[m*SELW +: SELW];
          m_ack[m]                = s_ack[s] & m_cyc[m];
          m_err[m]                = m_err[m] | (s_err[s] & m_cyc[m]);
          m_dat_i[m*DW +: DW]     = s_dat_i[s*DW +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_crossbar_rr.sv
// Scoreboard bench for wb_crossbar_rr: 2 masters, 3 slaves, directed transfers.
module tb_wb_crossbar_rr;

  localparam int unsigned NM = 2, NS = 3, AW = 32, DW = 32, SELW = DW / 8;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NM-1:0]        m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]     m_adr;
  logic [NM*DW-1:0]     m_dat_o;
  logic [NM*SELW-1:0]   m_sel;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM-1:0]        m_ack, m_err;
  logic [NS-1:0]        s_cyc, s_stb, s_we;
  logic [NS*AW-1:0]     s_adr;
  logic [NS*DW-1:0]     s_dat_o;
  logic [NS*SELW-1:0]   s_sel;
  logic [NS*DW-1:0]     s_dat_i;
  logic [NS-1:0]        s_ack, s_err;
  logic [NS-1:0]        ack_r, ack_force, err_force, slave_en;

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];

  always #5 clk = ~clk;

  assign s_dat_i = {32'h22222222, 32'h11111111, 32'hDEADBEEF};
  assign s_ack   = ack_r | ack_force;
  assign s_err   = err_force;

  wb_crossbar_rr #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW),
    .SLAVE_BASE({32'h00100010, 32'h00100000, 32'h00000000}),
    .SLAVE_MASK({32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFF00000})
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_o(m_dat_o), .m_sel(m_sel), .m_dat_i(m_dat_i),
    .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
    .s_ack(s_ack), .s_err(s_err)
  );

  // Slave model: one ACK pulse the cycle after it sees STB.
  initial begin
    logic [NS-1:0] nxt;
    ack_r = '0;
    forever begin
      @(negedge clk);
      nxt = s_cyc & s_stb & ~ack_r & slave_en;
      @(posedge clk);
      #1 ack_r = nxt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[m]                 = c;
    m_stb[m]                 = s;
    m_we[m]                  = w;
    m_adr[m*AW +: AW]        = adr;
    m_dat_o[m*DW +: DW]      = dat;
    m_sel[m*SELW +: SELW]    = '1;
  endtask

  task automatic push(input int m, input logic err, input logic [31:0] dat);
    exp_t e;
    e.err = err;
    e.dat = dat;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Counts edges until the master sees ACK or ERR; bounded.
  task automatic wait_resp(input int m, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (m_ack[m] || m_err[m]) break;
      lat++;
      if (lat > 50) begin
        check("resp timeout", 32'(m), 32'hFFFFFFFF);
        break;
      end
    end
    order_q.push_back(m);
  endtask

  task automatic finish_xfer(input int m);
    @(posedge clk);
    #1 drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int m, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic exp_err, input logic [31:0] exp_dat, output int lat);
    drive(m, 1'b1, 1'b1, we, adr, dat);
    push(m, exp_err, exp_dat);
    wait_resp(m, lat);
    finish_xfer(m);
  endtask

  // Monitor: every ACK/ERR a master sees must match the head of its queue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        if (m_ack[m] || m_err[m]) begin
          if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            check($sformatf("m%0d unexpected ack/err", m), {30'b0, m_ack[m], m_err[m]}, 32'h0);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("m%0d err flag", m), 32'(m_err[m]), 32'(e.err));
            if (!e.err) check($sformatf("m%0d rdata", m), m_dat_i[m*DW +: DW], e.dat);
          end
        end
      end
    end
  endtask

  task automatic run_tests();
    int lat0, lat1;

    // Main read: slave sees STB one cycle after the master.
    fork
      xfer(0, 32'h00000040, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, lat0);
      begin
        @(negedge clk) check("t1 s_stb0 same cycle", 32'(s_stb[0]), 32'h0);
        @(negedge clk) check("t1 s_stb0 next cycle", 32'(s_stb[0]), 32'h1);
      end
    join
    check("t1 latency", 32'(lat0), 32'd2);

    // Two masters, two slaves, same cycle.
    fork
      xfer(0, 32'h00000000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, lat0);
      xfer(1, 32'h00100004, 1'b0, 32'h0, 1'b0, 32'h11111111, lat1);
    join
    check("t2 m0 latency", 32'(lat0), 32'd2);
    check("t2 m1 latency", 32'(lat1), 32'd2);

    // Contention on slave1: grants alternate starting with M0.
    order_q.delete();
    fork
      for (int i = 0; i < 4; i++) xfer(0, 32'h00100000, 1'b0, 32'h0, 1'b0, 32'h11111111, lat0);
      for (int i = 0; i < 4; i++) xfer(1, 32'h00100008, 1'b0, 32'h0, 1'b0, 32'h11111111, lat1);
    join
    check("t3 grant count", 32'(order_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < order_q.size(); i++)
      check($sformatf("t3 grant order %0d", i), 32'(order_q[i]), 32'(i % 2));

    // Lock: route stays on slave0 after ADR moves into slave1's region.
    drive(0, 1'b1, 1'b1, 1'b1, 32'h00000010, 32'hCAFEF00D);
    push(0, 1'b0, 32'hDEADBEEF);
    fork
      wait_resp(0, lat0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t4 s_we0", 32'(s_we[0]), 32'h1);
        check("t4 s_dat_o0", s_dat_o[31:0], 32'hCAFEF00D);
        check("t4 s_sel0", 32'(s_sel[3:0]), 32'hF);
        check("t4 s_adr0", s_adr[31:0], 32'h00000010);
      end
    join
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b0, 1'b0, 32'h00100000, 32'h0);
    @(negedge clk);
    check("t4 s_cyc0 held", 32'(s_cyc[0]), 32'h1);
    check("t4 s_cyc1 idle", 32'(s_cyc[1]), 32'h0);
    @(posedge clk);
    #1 drive(0, 1'b1, 1'b1, 1'b0, 32'h00100000, 32'h0);
    push(0, 1'b0, 32'hDEADBEEF);
    fork
      wait_resp(0, lat0);
      begin
        @(negedge clk);
        check("t4 s_stb0 locked", 32'(s_stb[0]), 32'h1);
        check("t4 s_stb1 locked", 32'(s_stb[1]), 32'h0);
        check("t4 s_adr0 moved", s_adr[31:0], 32'h00100000);
      end
    join
    check("t4 locked latency", 32'(lat0), 32'd1);
    finish_xfer(0);

    // Unmapped: one-cycle ERR one cycle later, no slave touched.
    fork
      xfer(1, 32'h80000000, 1'b0, 32'h0, 1'b1, 32'h0, lat1);
      begin
        @(negedge clk) check("t5 s_cyc idle a", 32'(s_cyc), 32'h0);
        @(negedge clk) check("t5 s_cyc idle b", 32'(s_cyc), 32'h0);
        @(negedge clk) check("t5 no err after cyc drop", 32'(m_err[1]), 32'h0);
      end
    join
    check("t5 err latency", 32'(lat1), 32'd1);

    // Unmapped with STB held over three edges: ERR on each cycle CYC is high.
    drive(1, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'h0);
    push(1, 1'b1, 32'h0);
    push(1, 1'b1, 32'h0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk) check("t5 err gated by cyc", 32'(m_err[1]), 32'h0);
    @(posedge clk);
    #1;

    // Reset while slave2 busy: pointer returns to 0, so M0 wins afterwards.
    xfer(0, 32'h00100014, 1'b0, 32'h0, 1'b0, 32'h22222222, lat0);
    slave_en[2] = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h00100018, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0010001C, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t6 s_cyc2 before rst", 32'(s_cyc[2]), 32'h1);
    check("t6 rr owner before rst", s_adr[95:64], 32'h0010001C);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk) check("t6 s_cyc2 in rst", 32'(s_cyc[2]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) check("t6 s_cyc2 first cycle after rst", 32'(s_cyc[2]), 32'h0);
    @(negedge clk);
    check("t6 s_cyc2 regrant", 32'(s_cyc[2]), 32'h1);
    check("t6 owner after rst", s_adr[95:64], 32'h00100018);
    push(0, 1'b0, 32'h22222222);
    push(1, 1'b0, 32'h22222222);
    slave_en[2] = 1'b1;
    fork
      begin wait_resp(0, lat0); finish_xfer(0); end
      begin wait_resp(1, lat1); finish_xfer(1); end
    join

    // Slave responses while idle are not forwarded.
    @(posedge clk);
    #1 begin ack_force = '1; err_force = '1; end
    @(negedge clk);
    check("t7 idle ack", 32'(m_ack), 32'h0);
    check("t7 idle err", 32'(m_err), 32'h0);
    check("t7 idle dat m0", m_dat_i[31:0], 32'h0);
    check("t7 idle dat m1", m_dat_i[63:32], 32'h0);
    @(posedge clk);
    #1 begin ack_force = '0; err_force = '0; end

    repeat (3) @(posedge clk);
    check("q0 drained", 32'(q0.size()), 32'h0);
    check("q1 drained", 32'(q1.size()), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    m_cyc     = '0;
    m_stb     = '0;
    m_we      = '0;
    m_adr     = {32'h0, 32'h12345678};
    m_dat_o   = '0;
    m_sel     = '0;
    ack_force = '0;
    err_force = '0;
    slave_en  = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst s_cyc", 32'(s_cyc), 32'h0);
    check("rst s_stb", 32'(s_stb), 32'h0);
    check("rst m_ack", 32'(m_ack), 32'h0);
    check("rst m_err", 32'(m_err), 32'h0);
    for (int s = 0; s < NS; s++) check($sformatf("rst s_adr%0d", s), s_adr[s*AW +: AW], 32'h0);
    for (int m = 0; m < NM; m++) check($sformatf("rst m_dat_i%0d", m), m_dat_i[m*DW +: DW], 32'h0);
    @(posedge clk);
    #1 begin rst = 1'b0; m_adr = '0; end
    fork
      monitor();
      begin
        run_tests();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join_any
  end

endmodule
